// File: rtl/rv32i_types_pkg.sv
// RV32I decode types shared by the decode stage and its immediate generator.
package rv32i_types_pkg;

    typedef enum logic [6:0] {
        OpLui    = 7'b0110111,
        OpAuipc  = 7'b0010111,
        OpJal    = 7'b1101111,
        OpJalr   = 7'b1100111,
        OpBranch = 7'b1100011,
        OpLoad   = 7'b0000011,
        OpStore  = 7'b0100011,
        OpOpImm  = 7'b0010011,
        OpOp     = 7'b0110011,
        OpSystem = 7'b1110011
    } opcode_e;

    typedef enum logic [2:0] {
        FmtI,
        FmtS,
        FmtB,
        FmtU,
        FmtJ,
        FmtR
    } imm_fmt_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic        is_load;
        logic        reg_we;
        logic        illegal;
    } id_ex_t;

    // Unknown opcodes carry no immediate.
    function automatic imm_fmt_e imm_fmt(input logic [6:0] op);
        case (op)
            OpJalr, OpLoad, OpOpImm, OpSystem: return FmtI;
            OpStore:                           return FmtS;
            OpBranch:                          return FmtB;
            OpLui, OpAuipc:                    return FmtU;
            OpJal:                             return FmtJ;
            default:                           return FmtR;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Sign-extended RV32I immediate, format selected from the opcode field.
module imm_gen
    import rv32i_types_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [31:0] imm_o
);

    always_comb begin
        imm_o = '0;
        case (imm_fmt(instr_i[6:0]))
            FmtI: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            FmtS: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            FmtB: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                           instr_i[11:8], 1'b0};
            FmtU: imm_o = {instr_i[31:12], 12'b0};
            FmtJ: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                           instr_i[30:21], 1'b0};
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: decode, regfile read, load-use hazard bubble and ID/EX register.
module id_stage
    import rv32i_types_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        if_valid_i,
    input  logic [31:0] if_pc_i,
    input  logic [31:0] if_instr_i,
    output logic        id_ready_o,
    output logic [4:0]  rf_src_a_o,
    output logic [4:0]  rf_src_b_o,
    input  logic [31:0] rf_a_i,
    input  logic [31:0] rf_b_i,
    input  logic        ex_ready_i,
    input  logic        ex_flush_i,
    output logic        ex_valid_o,
    output logic [31:0] ex_pc_o,
    output logic [31:0] ex_rs1_data_o,
    output logic [31:0] ex_rs2_data_o,
    output logic [31:0] ex_imm_o,
    output logic [4:0]  ex_rs1_o,
    output logic [4:0]  ex_rs2_o,
    output logic [4:0]  ex_rd_o,
    output logic [6:0]  ex_opcode_o,
    output logic [2:0]  ex_funct3_o,
    output logic        ex_funct7b5_o,
    output logic        ex_is_load_o,
    output logic        ex_reg_we_o,
    output logic        ex_illegal_o
);

    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2, rd;
    logic        rs1_used, rs2_used, writes_rd, is_load, illegal;
    logic [31:0] imm;
    logic        advance, hazard;
    id_ex_t      dec, ex_d, ex_q;

    assign opcode = if_instr_i[6:0];
    assign rs1    = if_instr_i[19:15];
    assign rs2    = if_instr_i[24:20];
    assign rd     = if_instr_i[11:7];

    always_comb begin
        rs1_used  = 1'b1;
        rs2_used  = 1'b0;
        writes_rd = 1'b0;
        is_load   = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OpLui, OpAuipc, OpJal: begin
                rs1_used  = 1'b0;
                writes_rd = 1'b1;
            end
            OpJalr, OpOpImm:  writes_rd = 1'b1;
            OpLoad: begin
                writes_rd = 1'b1;
                is_load   = 1'b1;
            end
            OpBranch, OpStore: rs2_used = 1'b1;
            OpOp: begin
                rs2_used  = 1'b1;
                writes_rd = 1'b1;
            end
            OpSystem: ;
            default:  illegal = 1'b1;
        endcase
    end

    assign rf_src_a_o = rs1_used ? rs1 : 5'd0;
    assign rf_src_b_o = rs2_used ? rs2 : 5'd0;

    imm_gen u_imm_gen (
        .instr_i (if_instr_i),
        .imm_o   (imm)
    );

    assign advance = !ex_q.valid || ex_ready_i;
    assign hazard  = ex_q.valid && ex_q.is_load && (ex_q.rd != 5'd0) &&
                     ((rs1_used && rs1 == ex_q.rd) || (rs2_used && rs2 == ex_q.rd));
    assign id_ready_o = ex_flush_i || (advance && !hazard);

    // Source indices are stored masked so downstream forwarding ignores unused fields.
    always_comb begin
        dec          = '0;
        dec.valid    = 1'b1;
        dec.pc       = if_pc_i;
        dec.rs1_data = rf_a_i;
        dec.rs2_data = rf_b_i;
        dec.imm      = imm;
        dec.rs1      = rf_src_a_o;
        dec.rs2      = rf_src_b_o;
        dec.rd       = rd;
        dec.opcode   = opcode;
        dec.funct3   = if_instr_i[14:12];
        dec.funct7b5 = if_instr_i[30];
        dec.is_load  = is_load;
        dec.reg_we   = writes_rd && (rd != 5'd0);
        dec.illegal  = illegal;
    end

    always_comb begin
        ex_d = ex_q;
        if (ex_flush_i) begin
            ex_d.valid = 1'b0;
        end else if (!advance) begin
            ex_d = ex_q;
        end else if (hazard) begin
            ex_d.valid = 1'b0;
        end else if (if_valid_i) begin
            ex_d = dec;
        end else begin
            ex_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign ex_valid_o    = ex_q.valid;
    assign ex_pc_o       = ex_q.pc;
    assign ex_rs1_data_o = ex_q.rs1_data;
    assign ex_rs2_data_o = ex_q.rs2_data;
    assign ex_imm_o      = ex_q.imm;
    assign ex_rs1_o      = ex_q.rs1;
    assign ex_rs2_o      = ex_q.rs2;
    assign ex_rd_o       = ex_q.rd;
    assign ex_opcode_o   = ex_q.opcode;
    assign ex_funct3_o   = ex_q.funct3;
    assign ex_funct7b5_o = ex_q.funct7b5;
    assign ex_is_load_o  = ex_q.is_load;
    assign ex_reg_we_o   = ex_q.reg_we;
    assign ex_illegal_o  = ex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed cases plus randomized traffic against a model.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_pc = '0;
    logic [31:0] if_instr = '0;
    logic        id_ready;
    logic [4:0]  rf_src_a, rf_src_b;
    logic [31:0] rf_a, rf_b;
    logic        ex_ready = 1'b1;
    logic        ex_flush = 1'b0;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5, ex_is_load, ex_reg_we, ex_illegal;

    logic [31:0] regs [32];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    assign rf_a = regs[rf_src_a];
    assign rf_b = regs[rf_src_b];

    id_stage dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .if_valid_i    (if_valid),
        .if_pc_i       (if_pc),
        .if_instr_i    (if_instr),
        .id_ready_o    (id_ready),
        .rf_src_a_o    (rf_src_a),
        .rf_src_b_o    (rf_src_b),
        .rf_a_i        (rf_a),
        .rf_b_i        (rf_b),
        .ex_ready_i    (ex_ready),
        .ex_flush_i    (ex_flush),
        .ex_valid_o    (ex_valid),
        .ex_pc_o       (ex_pc),
        .ex_rs1_data_o (ex_rs1_data),
        .ex_rs2_data_o (ex_rs2_data),
        .ex_imm_o      (ex_imm),
        .ex_rs1_o      (ex_rs1),
        .ex_rs2_o      (ex_rs2),
        .ex_rd_o       (ex_rd),
        .ex_opcode_o   (ex_opcode),
        .ex_funct3_o   (ex_funct3),
        .ex_funct7b5_o (ex_funct7b5),
        .ex_is_load_o  (ex_is_load),
        .ex_reg_we_o   (ex_reg_we),
        .ex_illegal_o  (ex_illegal)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode: what each instruction means, built from field arithmetic.
    typedef struct {
        bit          r1u, r2u, we, ld, ill;
        logic [31:0] imm;
    } dec_t;

    function automatic dec_t mdec(input logic [31:0] i);
        dec_t        d;
        logic [31:0] ish;
        ish = 32'($signed(i) >>> 20);
        d.r1u = 1; d.r2u = 0; d.we = 0; d.ld = 0; d.ill = 0; d.imm = 0;
        case (i[6:0])
            7'h37, 7'h17: begin d.r1u = 0; d.we = 1; d.imm = i & 32'hFFFFF000; end
            7'h6F: begin
                d.r1u = 0; d.we = 1;
                d.imm = (ish & 32'hFFF00000) | (i & 32'h000FF000) | (32'(i[20]) << 11)
                        | (32'(i[30:21]) << 1);
            end
            7'h67, 7'h13: begin d.we = 1; d.imm = ish; end
            7'h03: begin d.we = 1; d.ld = 1; d.imm = ish; end
            7'h63: begin
                d.r2u = 1;
                d.imm = (ish & 32'hFFFFF000) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5)
                        | (32'(i[11:8]) << 1);
            end
            7'h23: begin d.r2u = 1; d.imm = (ish & ~32'h1F) | 32'(i[11:7]); end
            7'h33: begin d.r2u = 1; d.we = 1; end
            7'h73: d.imm = ish;
            default: d.ill = 1;
        endcase
        if (i[11:7] == 5'd0) d.we = 0;
        return d;
    endfunction

    // Model of the stage: holds the instruction word and captured operands.
    bit          m_valid = 0, m_zero = 1, consumed = 0;
    logic [31:0] m_ins = '0, m_pc = '0, m_a = '0, m_b = '0;

    function automatic bit m_hazard();
        dec_t d, e;
        d = mdec(if_instr);
        e = mdec(m_ins);
        return m_valid && e.ld && m_ins[11:7] != 0 &&
               ((d.r1u && if_instr[19:15] == m_ins[11:7]) ||
                (d.r2u && if_instr[24:20] == m_ins[11:7]));
    endfunction

    function automatic bit m_ready();
        return ex_flush || ((!m_valid || ex_ready) && !m_hazard());
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 0; m_zero = 1; consumed = 0;
        end else begin
            dec_t d;
            d = mdec(if_instr);
            consumed = if_valid && m_ready();
            if (ex_flush) m_valid = 0;
            else if (m_valid && !ex_ready) m_valid = 1;
            else if (m_hazard()) m_valid = 0;
            else if (if_valid) begin
                m_valid = 1; m_zero = 0;
                m_ins = if_instr; m_pc = if_pc;
                m_a = d.r1u ? regs[if_instr[19:15]] : 32'd0;
                m_b = d.r2u ? regs[if_instr[24:20]] : 32'd0;
            end else m_valid = 0;
        end
    end

    // Single compare process, mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            dec_t d, e;
            d = mdec(if_instr);
            e = mdec(m_ins);
            chk("id_ready", 32'(id_ready), 32'(m_ready()));
            chk("rf_src_a", 32'(rf_src_a), d.r1u ? 32'(if_instr[19:15]) : 32'd0);
            chk("rf_src_b", 32'(rf_src_b), d.r2u ? 32'(if_instr[24:20]) : 32'd0);
            chk("ex_valid", 32'(ex_valid), 32'(m_valid));
            if (m_valid) begin
                chk("ex_pc", ex_pc, m_pc);
                chk("ex_rs1_data", ex_rs1_data, m_a);
                chk("ex_rs2_data", ex_rs2_data, m_b);
                chk("ex_imm", ex_imm, e.imm);
                chk("ex_rs1", 32'(ex_rs1), e.r1u ? 32'(m_ins[19:15]) : 32'd0);
                chk("ex_rs2", 32'(ex_rs2), e.r2u ? 32'(m_ins[24:20]) : 32'd0);
                chk("ex_rd", 32'(ex_rd), 32'(m_ins[11:7]));
                chk("ex_ctrl", {20'd0, ex_opcode, ex_funct3, ex_funct7b5},
                    {20'd0, m_ins[6:0], m_ins[14:12], m_ins[30]});
                chk("ex_flags", {29'd0, ex_is_load, ex_reg_we, ex_illegal},
                    {29'd0, e.ld, e.we, e.ill});
            end else if (m_zero) begin
                chk("ex_zero", ex_pc | ex_imm | ex_rs1_data | ex_rs2_data |
                    32'({ex_rd, ex_rs1, ex_rs2, ex_opcode, ex_funct3, ex_funct7b5,
                         ex_is_load, ex_reg_we, ex_illegal}), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic rdy, input logic fl);
        if_valid = v; if_pc = pc; if_instr = ins; ex_ready = rdy; ex_flush = fl;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [6:0]  ops [11];
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73, 7'h7F};
        ins = $urandom;
        ins[6:0] = ops[$urandom_range(0, 10)];
        ins[11:7] = 5'($urandom_range(0, 6));
        ins[19:15] = 5'($urandom_range(0, 6));
        ins[24:20] = 5'($urandom_range(0, 6));
        return ins;
    endfunction

    logic [31:0] snap_pc, snap_imm;
    logic [4:0]  snap_rd;

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = (i == 0) ? 32'd0 : 32'h1000 + 32'(i);
        #12 rst_n = 1'b1;
        tick();

        // ADDI x1,x0,5
        drive(1, 32'h100, 32'h00500093, 1, 0);
        #1 chk("addi_src_a", 32'(rf_src_a), 32'd0);
        tick();
        chk("addi_valid", 32'(ex_valid), 32'd1);
        chk("addi_pc", ex_pc, 32'h100);
        chk("addi_imm", ex_imm, 32'd5);
        chk("addi_rd", 32'(ex_rd), 32'd1);
        chk("addi_we", 32'(ex_reg_we), 32'd1);
        chk("addi_rs1_data", ex_rs1_data, 32'd0);

        // LW x5,0(x2) then ADD x6,x5,x3
        drive(1, 32'h104, 32'h00012283, 1, 0);
        tick();
        drive(1, 32'h108, 32'h00328333, 1, 0);
        #1 chk("lu_ready_low", 32'(id_ready), 32'd0);
        tick();
        chk("lu_bubble", 32'(ex_valid), 32'd0);
        tick();
        chk("lu_add_valid", 32'(ex_valid), 32'd1);
        chk("lu_add_pc", ex_pc, 32'h108);
        chk("lu_add_rs2_data", ex_rs2_data, 32'h1003);

        // BEQ x0,x0,-4
        drive(1, 32'h10C, 32'hFE000EE3, 1, 0);
        #1 chk("beq_src_b", 32'(rf_src_b), 32'd0);
        tick();
        chk("beq_imm", ex_imm, 32'hFFFFFFFC);
        chk("beq_we", 32'(ex_reg_we), 32'd0);

        // Downstream stall for 3 cycles
        drive(1, 32'h110, 32'h00700113, 1, 0);
        tick();
        snap_pc = ex_pc; snap_imm = ex_imm; snap_rd = ex_rd;
        drive(1, 32'h114, 32'h00900193, 0, 0);
        for (int c = 0; c < 3; c++) begin
            #1 chk("stall_ready", 32'(id_ready), 32'd0);
            tick();
            chk("stall_pc", ex_pc, snap_pc);
            chk("stall_imm", ex_imm, snap_imm);
            chk("stall_rd", 32'(ex_rd), 32'(snap_rd));
        end
        ex_ready = 1'b1;
        tick();
        chk("release_pc", ex_pc, 32'h114);

        // Flush wins over a stalled execute
        drive(1, 32'h118, 32'h00B00213, 0, 1);
        #1 chk("flush_ready", 32'(id_ready), 32'd1);
        tick();
        chk("flush_valid", 32'(ex_valid), 32'd0);

        // Flush during a load-use stall
        drive(1, 32'h11C, 32'h00012283, 1, 0);
        tick();
        drive(1, 32'h120, 32'h00328333, 1, 1);
        #1 chk("flush_lu_ready", 32'(id_ready), 32'd1);
        tick();
        chk("flush_lu_valid", 32'(ex_valid), 32'd0);
        drive(1, 32'h124, 32'h00328333, 1, 0);
        #1 chk("flush_lu_no_haz", 32'(id_ready), 32'd1);

        // Asynchronous reset mid-cycle
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(ex_valid), 32'd0);
        chk("rst_pc", ex_pc, 32'd0);
        chk("rst_imm", ex_imm, 32'd0);
        chk("rst_flags", {27'd0, ex_rd}, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        tick();
        drive(1, 32'h200, 32'h00000FFF, 1, 0);
        tick();
        chk("ill_valid", 32'(ex_valid), 32'd1);
        chk("ill_illegal", 32'(ex_illegal), 32'd1);
        chk("ill_we", 32'(ex_reg_we), 32'd0);

        // Randomized traffic
        drive(0, 32'h300, rand_instr(), 1, 0);
        for (int c = 0; c < 600; c++) begin
            tick();
            regs[$urandom_range(1, 31)] = $urandom;
            if (!if_valid || consumed) begin
                if_valid = ($urandom_range(0, 4) != 0);
                if_pc = if_pc + 32'd4;
                if_instr = rand_instr();
            end
            ex_ready = ($urandom_range(0, 3) != 0);
            ex_flush = ($urandom_range(0, 11) == 0);
        end
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
